// File: rtl/servo_array.sv
// servo_array: memory-mapped multi-channel RC-servo PWM generator with frame-synchronous updates.
// Define SERVO_SLEW_EN to add the per-frame slew limiter and its STEP register.
module servo_array #(
  parameter int         CHANNELS     = 4,
  parameter logic [7:0] BASE_ADDRESS = 8'h00,
  parameter int         PRESCALE     = 102,
  parameter int         PERIOD_TICKS = 3160,
  parameter int         MIN_TICKS    = 92,
  parameter int         CNT_W        = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          din,
  input  logic [7:0]          address,
  input  logic                w_en,
  input  logic                r_en,
  output logic [7:0]          dout,
  output logic [CHANNELS-1:0] servo_pins,
  output logic                frame_irq
);

  localparam int         PS_W       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int         CMP_W      = 9 + CNT_W;
  localparam logic [7:0] ENABLE_OFF = 8'(CHANNELS);
  localparam logic [7:0] STATUS_OFF = 8'(CHANNELS + 1);
`ifdef SERVO_SLEW_EN
  localparam logic [7:0] STEP_OFF   = 8'(CHANNELS + 2);
`endif

  logic [7:0]          target [CHANNELS];
  logic [7:0]          active [CHANNELS];
  logic [CHANNELS-1:0] enable_reg;
  logic [CHANNELS-1:0] ena_sh;
  logic [PS_W-1:0]     prescaler;
  logic [CNT_W-1:0]    counter;
  logic                frame_flag;
  logic [7:0]          offset;
  logic [7:0]          rd_data;
  logic                tick;
  logic                wrap;
  logic                busy;
  logic                status_rd;
`ifdef SERVO_SLEW_EN
  logic [7:0]          step_val;

  // Move cur toward tgt by at most stp without overshoot; stp of zero jumps straight to tgt.
  function automatic logic [7:0] slew(input logic [7:0] cur, input logic [7:0] tgt,
                                      input logic [7:0] stp);
    logic [8:0] diff;
    logic [8:0] amt;
    if (stp == 8'd0 || cur == tgt) return tgt;
    if (tgt > cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      amt  = (diff < {1'b0, stp}) ? diff : {1'b0, stp};
      return 8'({1'b0, cur} + amt);
    end
    diff = {1'b0, cur} - {1'b0, tgt};
    amt  = (diff < {1'b0, stp}) ? diff : {1'b0, stp};
    return 8'({1'b0, cur} - amt);
  endfunction
`endif

  assign offset    = address - BASE_ADDRESS;
  assign tick      = (prescaler == PS_W'(PRESCALE - 1));
  assign wrap      = tick && (counter == CNT_W'(PERIOD_TICKS - 1));
  assign status_rd = r_en && (offset == STATUS_OFF);
  assign frame_irq = frame_flag;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < CHANNELS; i++)
      if (active[i] != target[i]) busy = 1'b1;
  end

  // Unmapped offsets fall through to zero.
  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < CHANNELS; i++)
      if (offset == 8'(i)) rd_data = target[i];
    if (offset == ENABLE_OFF) rd_data = 8'(enable_reg);
    if (offset == STATUS_OFF) rd_data = {6'b0, busy, frame_flag};
`ifdef SERVO_SLEW_EN
    if (offset == STEP_OFF) rd_data = step_val;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout <= 8'h00;
    else     dout <= r_en ? rd_data : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      counter   <= '0;
    end else if (tick) begin
      prescaler <= '0;
      counter   <= wrap ? '0 : counter + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) target[i] <= 8'h00;
      enable_reg <= '0;
`ifdef SERVO_SLEW_EN
      step_val   <= 8'h00;
`endif
    end else if (w_en) begin
      for (int i = 0; i < CHANNELS; i++)
        if (offset == 8'(i)) target[i] <= din;
      if (offset == ENABLE_OFF) enable_reg <= din[CHANNELS-1:0];
`ifdef SERVO_SLEW_EN
      if (offset == STEP_OFF) step_val <= din;
`endif
    end
  end

  // Shadow enable and active positions only change at the frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ena_sh <= '0;
      for (int i = 0; i < CHANNELS; i++) active[i] <= 8'h00;
    end else if (wrap) begin
      ena_sh <= enable_reg;
      for (int i = 0; i < CHANNELS; i++) begin
`ifdef SERVO_SLEW_EN
        active[i] <= slew(active[i], target[i], step_val);
`else
        active[i] <= target[i];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            frame_flag <= 1'b0;
    else if (wrap)      frame_flag <= 1'b1;
    else if (status_rd) frame_flag <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      servo_pins <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++)
        servo_pins[i] <= ena_sh[i] &&
                         ({9'b0, counter} < (CMP_W'(MIN_TICKS) + CMP_W'(active[i])));
    end
  end

endmodule

// File: tb/tb_servo_array.sv
// tb_servo_array: randomized and directed checks of servo_array against a frame-level reference model.
// The model derives pin levels from the edge count since reset, not from counter state.
module tb_servo_array;

  localparam int         CH    = 4;
  localparam int         PS    = 4;
  localparam int         PER   = 300;
  localparam int         MINT  = 10;
  localparam int         CW    = 12;
  localparam int         FRAME = PS * PER;
  localparam logic [7:0] BASE  = 8'h00;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    din;
  logic [7:0]    address;
  logic          w_en;
  logic          r_en;
  logic [7:0]    dout;
  logic [CH-1:0] servo_pins;
  logic          frame_irq;

  servo_array #(
    .CHANNELS(CH), .BASE_ADDRESS(BASE), .PRESCALE(PS),
    .PERIOD_TICKS(PER), .MIN_TICKS(MINT), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .address(address), .w_en(w_en), .r_en(r_en),
    .dout(dout), .servo_pins(servo_pins), .frame_irq(frame_irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int            m_target [CH];
  int            m_active [CH];
  logic [CH-1:0] m_enable;
  logic [CH-1:0] m_ena_sh;
  int            m_step;
  int            m_flag;
  longint        edge_n;
  int            hi0;
  int            hi_rest;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int modelBusy();
    for (int i = 0; i < CH; i++)
      if (m_active[i] != m_target[i]) return 1;
    return 0;
  endfunction

  function automatic int regValue(input int off);
    if (off < CH) return m_target[off];
    if (off == CH) return int'(m_enable);
    if (off == CH + 1) return m_flag + 2 * modelBusy();
`ifdef SERVO_SLEW_EN
    if (off == CH + 2) return m_step;
`endif
    return 0;
  endfunction

  function automatic int slewTo(input int cur, input int tgt, input int stp);
    if (stp == 0) return tgt;
    if (tgt > cur) return cur + ((tgt - cur < stp) ? tgt - cur : stp);
    return cur - ((cur - tgt < stp) ? cur - tgt : stp);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < CH; i++) begin
      m_target[i] = 0;
      m_active[i] = 0;
    end
    m_enable = '0;
    m_ena_sh = '0;
    m_step   = 0;
    m_flag   = 0;
    edge_n   = 0;
    hi0      = 0;
    hi_rest  = 0;
  endtask

  // One bus cycle: drive, advance the model across the edge, then compare all outputs.
  task automatic applyStimulus(input logic we, input logic re, input logic [7:0] a,
                               input logic [7:0] d);
    logic [7:0] off8;
    int         off;
    int         pos;
    int         exp_dout;
    int         exp_pins;
    bit         wrap;
    w_en = we; r_en = re; address = a; din = d;
    @(posedge clk);
    edge_n++;
    off8 = a - BASE;
    off  = int'(off8);
    pos  = int'((edge_n - 1) % FRAME);
    exp_pins = 0;
    for (int i = 0; i < CH; i++)
      if (m_ena_sh[i] && pos < (MINT + m_active[i]) * PS) exp_pins += (1 << i);
    exp_dout = re ? regValue(off) : 0;
    wrap = (edge_n % FRAME == 0);
    if (wrap) begin
      m_ena_sh = m_enable;
      for (int i = 0; i < CH; i++) begin
`ifdef SERVO_SLEW_EN
        m_active[i] = slewTo(m_active[i], m_target[i], m_step);
`else
        m_active[i] = m_target[i];
`endif
      end
    end
    if (we) begin
      if (off < CH) m_target[off] = int'(d);
      else if (off == CH) m_enable = d[CH-1:0];
`ifdef SERVO_SLEW_EN
      else if (off == CH + 2) m_step = int'(d);
`endif
    end
    if (re && off == CH + 1) m_flag = 0;
    if (wrap) m_flag = 1;
    #1;
    checkOutput("dout", 32'(dout), 32'(exp_dout));
    checkOutput("pins", 32'(servo_pins), 32'(exp_pins));
    checkOutput("irq", 32'(frame_irq), 32'(m_flag));
    hi0     += int'(servo_pins[0]);
    hi_rest += int'(servo_pins[CH-1:1] != '0);
  endtask

  task automatic writeReg(input logic [7:0] a, input logic [7:0] d);
    applyStimulus(1'b1, 1'b0, a, d);
  endtask

  task automatic readReg(input logic [7:0] a);
    applyStimulus(1'b0, 1'b1, a, 8'h00);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic idleToBoundary();
    while (edge_n % FRAME != 0) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic doReset();
    w_en = 1'b0; r_en = 1'b0; address = 8'h00; din = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

`ifdef SERVO_SLEW_EN
  int slew_w [4]    = '{240, 440, 520, 520};
  int slew_stat [4] = '{3, 3, 1, 1};
`endif

  initial begin
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; address = 8'h00; din = 8'h00;
    doReset();
    #1;
    checkOutput("reset_dout", 32'(dout), 32'h0);
    checkOutput("reset_pins", 32'(servo_pins), 32'h0);
    checkOutput("reset_irq", 32'(frame_irq), 32'h0);

    // Frame 0 is silent, then exact pulse widths; mid-frame writes defer to the next frame.
    writeReg(BASE + CH, 8'h01);
    writeReg(BASE + 0, 8'd20);
    idleToBoundary();
    checkOutput("frame0_pulse", 32'(hi0), 32'd0);
    hi0 = 0; hi_rest = 0;
    idleCycles(FRAME);
    checkOutput("width_20", 32'(hi0), 32'd120);
    checkOutput("other_pins", 32'(hi_rest), 32'd0);
    hi0 = 0;
    idleCycles(500); writeReg(BASE + 0, 8'd0); idleCycles(FRAME - 501);
    checkOutput("width_midwrite_0", 32'(hi0), 32'd120);
    hi0 = 0;
    idleCycles(20); writeReg(BASE + 0, 8'd255); idleCycles(FRAME - 21);
    checkOutput("width_0", 32'(hi0), 32'd40);
    hi0 = 0;
    idleCycles(FRAME);
    checkOutput("width_255", 32'(hi0), 32'd1060);

    // Asynchronous reset while pin0 is high.
    idleCycles(10);
    readReg(BASE + 0);
    checkOutput("pin0_before_reset", 32'(servo_pins[0]), 32'd1);
    checkOutput("dout_before_reset", 32'(dout), 32'hFF);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_pins", 32'(servo_pins), 32'h0);
    checkOutput("async_dout", 32'(dout), 32'h0);
    checkOutput("async_irq", 32'(frame_irq), 32'h0);
    doReset();
    idleCycles(2 * FRAME);
    checkOutput("no_pulse_after_reset", 32'(hi0), 32'd0);
    readReg(BASE + 0);
    checkOutput("target0_after_reset", 32'(dout), 32'h0);
    readReg(BASE + CH);
    checkOutput("enable_after_reset", 32'(dout), 32'h0);
    writeReg(BASE + CH, 8'h01);
    idleToBoundary();
    checkOutput("no_pulse_before_boundary", 32'(hi0), 32'd0);
    hi0 = 0;
    idleCycles(FRAME);
    checkOutput("pulse_after_reenable", 32'(hi0), 32'd40);

    // Register readback, enable masking, unmapped read, read-during-write.
    writeReg(BASE + 2, 8'hA5);
    writeReg(BASE + CH, 8'hFB);
    readReg(BASE + 2);
    checkOutput("rd_target2", 32'(dout), 32'hA5);
    readReg(BASE + CH);
    checkOutput("rd_enable", 32'(dout), 32'h0B);
    readReg(8'h40);
    checkOutput("rd_unmapped", 32'(dout), 32'h00);
    writeReg(BASE + 1, 8'h33);
    applyStimulus(1'b1, 1'b1, BASE + 1, 8'h77);
    checkOutput("rw_same_cycle", 32'(dout), 32'h33);
    readReg(BASE + 1);
    checkOutput("rd_after_rw", 32'(dout), 32'h77);

    // Frame flag set/clear, set winning over a coincident clear, busy bit.
    writeReg(BASE + CH + 2, 8'h00);
    idleToBoundary();
    checkOutput("irq_at_wrap", 32'(frame_irq), 32'd1);
    readReg(BASE + CH + 1);
    checkOutput("status_flag", 32'(dout), 32'h01);
    checkOutput("irq_cleared", 32'(frame_irq), 32'd0);
    readReg(BASE + CH + 1);
    checkOutput("status_cleared", 32'(dout), 32'h00);
    while (edge_n % FRAME != FRAME - 1) idleCycles(1);
    readReg(BASE + CH + 1);
    checkOutput("status_on_wrap", 32'(dout), 32'h00);
    checkOutput("irq_set_wins", 32'(frame_irq), 32'd1);
    readReg(BASE + CH + 1);
    checkOutput("status_after_wrap", 32'(dout), 32'h01);
    writeReg(BASE + 0, 8'd77);
    readReg(BASE + CH + 1);
    checkOutput("status_busy", 32'(dout), 32'h02);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int n = 0; n < 9000; n++) begin
      logic [7:0] a;
      logic       we;
      logic       re;
      a  = ($urandom_range(0, 15) == 0) ? 8'($urandom) : BASE + 8'($urandom_range(0, CH + 3));
      we = ($urandom_range(0, 7) == 0);
      re = ($urandom_range(0, 3) == 0);
      applyStimulus(we, re, a, 8'($urandom));
    end

`ifdef SERVO_SLEW_EN
    // Slew ramp 0 -> 120 in steps of 50.
    doReset();
    writeReg(BASE + CH + 2, 8'd50);
    writeReg(BASE + CH, 8'h01);
    writeReg(BASE + 0, 8'd120);
    for (int k = 0; k < 4; k++) begin
      idleToBoundary();
      if (k > 0) checkOutput("slew_width", 32'(hi0), 32'(slew_w[k-1]));
      hi0 = 0;
      readReg(BASE + CH + 1);
      checkOutput("slew_status", 32'(dout), 32'(slew_stat[k]));
    end
    idleToBoundary();
    checkOutput("slew_width_final", 32'(hi0), 32'(slew_w[3]));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
